// File: rtl/bchecc_seq_pkg.sv
// rtl/bchecc_seq_pkg.sv - shared constants, FSM encoding and helpers for the BCH page sequencer
package bchecc_seq_pkg;

  // engine SFR register addresses
  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_CFG  = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  // CTRL bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_OPT   = 1;

  // STAT bit positions (busy and error bits are informational only here)
  localparam int STAT_FAIL    = 2;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 7;

  localparam logic [1:0] SFR_SIZE_WORD = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CTRL,
    S_XFER,
    S_WAIT,
    S_STAT,
    S_CHK,
    S_NEXT,
    S_DONE
  } state_t;

  // CTRL word for a given start bit and direction
  function automatic logic [31:0] ctrl_word(input logic start, input logic dec);
    ctrl_word = '0;
    ctrl_word[CTRL_START] = start;
    ctrl_word[CTRL_OPT]   = dec;
  endfunction

endpackage

// File: rtl/bchecc_seq_sfr.sv
// rtl/bchecc_seq_sfr.sv - turns one-cycle read/write requests into registered SFR strobes
module bchecc_seq_sfr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        sfr_en_o,
  output logic        sfr_rd_o,
  output logic        sfr_wr_o,
  output logic [3:0]  sfr_addr_o,
  output logic [31:0] sfr_wdata_o
);

  // register the request so each access is a clean single-cycle strobe; a write wins over a read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfr_en_o    <= 1'b0;
      sfr_rd_o    <= 1'b0;
      sfr_wr_o    <= 1'b0;
      sfr_addr_o  <= '0;
      sfr_wdata_o <= '0;
    end else begin
      sfr_en_o <= wr_req | rd_req;
      sfr_rd_o <= rd_req & ~wr_req;
      sfr_wr_o <= wr_req;
      if (wr_req | rd_req) sfr_addr_o <= addr;
      if (wr_req) sfr_wdata_o <= wdata;
    end
  end

endmodule

// File: rtl/bchecc_seq.sv
// rtl/bchecc_seq.sv - page-level sequencer driving the BCH ECC engine sector by sector
module bchecc_seq
  import bchecc_seq_pkg::*;
#(
  parameter int SECT_BYTES = 512,
  parameter int TMO_CYC    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        page_start_i,
  input  logic        page_dec_i,
  input  logic [3:0]  sect_num_i,
  input  logic [9:0]  ecc_cfg_i,
  input  logic        abort_i,
  input  logic        din_valid_i,
  input  logic [7:0]  din_data_i,
  output logic        din_ready_o,
  output logic        page_busy_o,
  output logic        page_done_o,
  output logic        page_fail_o,
  output logic [15:0] fail_map_o,
  output logic [3:0]  err_max_o,
  output logic        sfr_en_o,
  output logic        sfr_rd_o,
  output logic        sfr_wr_o,
  output logic [1:0]  sfr_size_o,
  output logic [3:0]  sfr_addr_o,
  output logic [31:0] sfr_wdata_o,
  input  logic [31:0] sfr_rdata_i,
  output logic        ecc_wr_o,
  output logic [7:0]  ecc_data_o,
  input  logic        ecc_done_i
);

  localparam int BCW = $clog2(SECT_BYTES) + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(SECT_BYTES - 1);
  localparam logic [11:0]    WD_LAST   = 12'(TMO_CYC - 1);

  state_t          state, next_state;
  logic            dec_q;
  logic [3:0]      num_q;
  logic [3:0]      sect_q;
  logic [BCW-1:0]  byte_cnt;
  logic [11:0]     wd_cnt;
  logic            abort_hit, accept, wd_expire;
  logic            wr_req, rd_req;
  logic [3:0]      req_addr;
  logic [31:0]     req_wdata;
  logic            stat_fail;
  logic [3:0]      stat_cnt;
  logic            unused_rdata;

  assign abort_hit = abort_i && (state != S_IDLE) && (state != S_DONE);
  assign accept    = (state == S_XFER) && din_valid_i;
  assign wd_expire = (wd_cnt == WD_LAST);
  assign stat_fail = sfr_rdata_i[STAT_FAIL];
  assign stat_cnt  = sfr_rdata_i[STAT_CNT_MSB:STAT_CNT_LSB];
  assign unused_rdata = ^{sfr_rdata_i[31:8], sfr_rdata_i[3], sfr_rdata_i[1:0]};
  assign sfr_size_o = SFR_SIZE_WORD;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // next-state logic; abort overrides every non-idle transition
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (page_start_i) next_state = S_CFG;
      S_CFG:  next_state = S_CTRL;
      S_CTRL: next_state = S_XFER;
      S_XFER: if (accept && byte_cnt == LAST_BYTE) next_state = S_WAIT;
      S_WAIT: begin
        if (ecc_done_i)     next_state = dec_q ? S_STAT : S_NEXT;
        else if (wd_expire) next_state = S_NEXT;
      end
      S_STAT: next_state = S_CHK;
      S_CHK:  next_state = S_NEXT;
      S_NEXT: next_state = (sect_q == num_q) ? S_DONE : S_CTRL;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort_hit) next_state = S_DONE;
  end

  // outputs: byte path from the current state, SFR requests from the state being entered
  always_comb begin
    din_ready_o = (state == S_XFER);
    ecc_wr_o    = accept;
    ecc_data_o  = accept ? din_data_i : 8'h00;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    req_addr    = ADDR_CTRL;
    req_wdata   = '0;
    if (abort_hit) begin
      wr_req = 1'b1;
    end else begin
      case (next_state)
        S_CFG: begin
          wr_req    = 1'b1;
          req_addr  = ADDR_CFG;
          req_wdata = {22'd0, ecc_cfg_i};
        end
        S_CTRL: begin
          wr_req    = 1'b1;
          req_wdata = ctrl_word(1'b1, dec_q);
        end
        S_STAT: begin
          rd_req   = 1'b1;
          req_addr = ADDR_STAT;
        end
        default: ;
      endcase
    end
  end

  // page context, counters and verdict aggregation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= 1'b0;
      num_q       <= '0;
      sect_q      <= '0;
      byte_cnt    <= '0;
      wd_cnt      <= '0;
      fail_map_o  <= '0;
      err_max_o   <= '0;
      page_fail_o <= 1'b0;
      page_done_o <= 1'b0;
      page_busy_o <= 1'b0;
    end else begin
      page_done_o <= (state == S_DONE);
      page_busy_o <= (next_state != S_IDLE);
      byte_cnt    <= (state == S_XFER) ? byte_cnt + BCW'(accept) : '0;
      wd_cnt      <= (state == S_WAIT) ? wd_cnt + 12'd1 : '0;
      if (state == S_IDLE && page_start_i) begin
        dec_q       <= page_dec_i;
        num_q       <= sect_num_i;
        sect_q      <= '0;
        fail_map_o  <= '0;
        err_max_o   <= '0;
        page_fail_o <= 1'b0;
      end
      if (abort_hit) begin
        fail_map_o[sect_q] <= 1'b1;
      end else begin
        case (state)
          S_WAIT: if (!ecc_done_i && wd_expire) fail_map_o[sect_q] <= 1'b1;
          S_CHK: begin
            if (stat_fail)               fail_map_o[sect_q] <= 1'b1;
            else if (stat_cnt > err_max_o) err_max_o <= stat_cnt;
          end
          S_NEXT: if (sect_q != num_q) sect_q <= sect_q + 4'd1;
          S_DONE: page_fail_o <= |fail_map_o;
          default: ;
        endcase
      end
    end
  end

  bchecc_seq_sfr u_sfr (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .addr        (req_addr),
    .wdata       (req_wdata),
    .sfr_en_o    (sfr_en_o),
    .sfr_rd_o    (sfr_rd_o),
    .sfr_wr_o    (sfr_wr_o),
    .sfr_addr_o  (sfr_addr_o),
    .sfr_wdata_o (sfr_wdata_o)
  );

endmodule

// File: doc/bchecc_seq.md
# bchecc_seq

Page-level sequencer for the BCH ECC engine. Splits a NAND page into up to 16 sectors and, for each one, programs the engine through its SFR port. It then streams the sector bytes, waits for the engine's done flag and reads back status. Per-sector results are aggregated into a page verdict. Sits between the NAND channel datapath and the ECC core, and replaces CPU-driven per-sector SFR traffic.

## Interface
Parameters:
- SECT_BYTES, 512: bytes streamed per sector (excludes parity handled inside the core)
- TMO_CYC, 4095: max cycles waiting for ecc_done_i before the sector is declared failed

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- page_start_i  in  1  one-cycle pulse that starts a page; ignored unless idle
- page_dec_i  in  1  1 = decode, 0 = encode; sampled with page_start_i
- sect_num_i  in  4  sectors minus 1; sampled with page_start_i
- ecc_cfg_i  in  10  engine CFG value; sampled with page_start_i
- abort_i  in  1  abort the page
- din_valid_i  in  1  byte valid
- din_data_i  in  8  byte
- din_ready_o  out  1  byte accepted when valid & ready
- page_busy_o  out  1  page in progress
- page_done_o  out  1  one-cycle completion pulse
- page_fail_o  out  1  any sector uncorrectable, timed out or aborted
- fail_map_o  out  16  bit n = sector n failed
- err_max_o  out  4  largest corrected-error count over the page
- sfr_en_o, sfr_rd_o, sfr_wr_o  out  1 each  engine SFR strobes
- sfr_size_o  out  2  fixed 2'b10 (word)
- sfr_addr_o  out  4  register address
- sfr_wdata_o  out  32  write data
- sfr_rdata_i  in  32  read data
- ecc_wr_o  out  1  byte strobe to engine
- ecc_data_o  out  8  byte to engine
- ecc_done_i  in  1  engine sector-complete pulse

## Operation
- Engine register map:
  - CTRL = 4'h0: bit0 start, bit1 opt (1 = decode).
  - CFG = 4'h4: [9:0].
  - STAT = 4'h8: bit0 busy, bit1 error, bit2 correct_fail, [7:4] error count.
- FSM states and transitions:
  - IDLE → CFG on page_start_i. Latch inputs, clear fail_map_o and err_max_o, set the sector counter to 0.
  - CFG: one SFR write of CFG, then → CTRL.
  - CTRL: one SFR write of CTRL with bit0 = 1 and bit1 = page_dec_i, then → XFER.
  - XFER: din_ready_o = 1. Each accepted byte gives ecc_wr_o = 1 with ecc_data_o = din_data_i in the same cycle. After SECT_BYTES bytes → WAIT.
  - WAIT: watchdog counts. On ecc_done_i → STAT. If the count reaches TMO_CYC, set fail_map_o[sector] and → NEXT.
  - STAT: one SFR read of STAT, then → CHK.
  - CHK: sample sfr_rdata_i.
    - If bit2 is set, set fail_map_o[sector].
    - Otherwise, if [7:4] exceeds err_max_o, update err_max_o.
    - Encode pages skip STAT and CHK: WAIT → NEXT on ecc_done_i.
  - NEXT: if sector == latched sect_num_i → DONE. Otherwise increment the sector counter and → CTRL; CFG is written once per page.
  - DONE: page_done_o = 1 for one cycle, page_fail_o = |fail_map_o, then → IDLE.
- abort_i in any non-IDLE state:
  - Next cycle is one SFR write of CTRL = 0.
  - Then DONE with fail_map_o[sector] set.
- Outside XFER, din_ready_o = 0 and ecc_wr_o = 0.
- page_start_i received while busy is dropped.

## Timing
- All outputs are registered except din_ready_o and ecc_wr_o/ecc_data_o, which are combinational from the state and din_valid_i.
- Reset values: every output is 0 except sfr_size_o = 2'b10.
- An SFR access is a single-cycle strobe: sfr_en_o = 1 together with either sfr_rd_o or sfr_wr_o.
- Read data is valid the cycle after the read strobe.
- Fixed per-sector overhead from the last XFER byte:
  - encode: WAIT, NEXT, CTRL, plus the engine latency;
  - decode: additionally STAT and CHK (2 cycles).
- ecc_done_i arriving in the same cycle as the watchdog expiry is treated as done.
- ecc_done_i outside WAIT is ignored.
- When abort_i coincides with ecc_done_i, abort wins.
- The byte counter is log2(SECT_BYTES) + 1 bits.
- The watchdog counter is 12 bits and clears on WAIT entry.
- Reset mid-page returns to IDLE immediately and issues no SFR access.

## Structure
- Shared package holds:
  - SFR addresses CTRL/CFG/STAT;
  - STAT and CTRL bit positions;
  - the FSM state encoding, with 9 states in one-hot or binary form.
- Single module. A small sub-module bchecc_seq_sfr issues SFR accesses (write/read request → strobes and address) and is shared by CFG, CTRL, STAT and the abort path.

## Test plan
- Encode, sect_num_i = 0, SECT_BYTES = 512, done 20 cycles after the last byte:
  - exactly 512 ecc_wr_o pulses;
  - CFG write, then CTRL write of 32'h1;
  - page_done_o with page_fail_o = 0.
- Decode of 4 sectors, STAT error counts 3, 7, 0, 2:
  - CTRL = 32'h3 written 4 times and CFG written once;
  - err_max_o = 7, fail_map_o = 0.
- Decode of 2 sectors with sector 1 STAT = 32'h4:
  - fail_map_o = 16'h0002, page_fail_o = 1.
- ecc_done_i withheld on sector 0 of 1:
  - timeout after 4095 cycles, fail_map_o = 16'h0001.
- din_valid_i toggled every other cycle:
  - no ecc_wr_o when din_valid_i is low;
  - the byte order is preserved.
- abort_i during XFER of sector 2:
  - SFR write CTRL = 0;
  - page_done_o follows with fail_map_o bit 2 set;
  - a page_start_i issued during busy is ignored.
